axis_frame_len_mc: RTL and testbench
====================================

Name: axis_frame_len_mc

Overview:
Passive multi-channel AXI4-Stream frame length monitor. It taps a stream carrying interleaved frames tagged by tid and keeps an independent byte-lane counter per ID. On each tlast it pushes a status record {id, length, overflow} into an internal status FIFO, which is drained through a ready/valid status port. It sits beside MAC/switch datapaths for per-flow statistics and never back-pressures the monitored stream.

Parameters:
DATA_WIDTH, 64, monitored tdata width in bits (tdata itself is not a port).
KEEP_ENABLE, (DATA_WIDTH>8), use tkeep; if 0, each beat counts 1.
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
ID_WIDTH, 2, tid width; channel count = 2**ID_WIDTH.
LEN_WIDTH, 16, length counter width.
FIFO_DEPTH, 4, status FIFO entries; power of two, >= 2.
DROP_WIDTH, 16, dropped-status counter width.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
monitor_axis_tkeep  input  KEEP_WIDTH  monitored tkeep
monitor_axis_tid  input  ID_WIDTH  monitored tid, selects channel
monitor_axis_tvalid  input  1  monitored tvalid
monitor_axis_tready  input  1  monitored tready
monitor_axis_tlast  input  1  monitored tlast
status_id  output  ID_WIDTH  channel of the completed frame
status_len  output  LEN_WIDTH  frame length in bytes (beats if KEEP_ENABLE=0)
status_overflow  output  1  length saturated during this frame
status_valid  output  1  status record available
status_ready  input  1  consumer accepts the record
drop_count  output  DROP_WIDTH  records lost because the FIFO was full

Behaviour:
- Reset: rst_n=0 at a clock edge clears every channel counter and overflow flag, empties the FIFO, and sets status_valid=0 and drop_count=0. Status outputs read 0 while the FIFO is empty. A frame in progress during reset is discarded with no record.
- Beat: tvalid && tready. inc = popcount(tkeep) (any bit pattern, including non-contiguous) if KEEP_ENABLE, else 1. Beats with tkeep=0 add 0. Other beats are ignored.
- Per channel c = tid: sum = len[c] + inc, computed LEN_WIDTH+1 wide. If sum > 2**LEN_WIDTH-1, the result saturates to all-ones and ovf[c] is set. Otherwise len[c] <= sum.
- tlast beat: the record {c, saturated sum, ovf[c] | this-beat overflow} is pushed to the FIFO. len[c] and ovf[c] clear to 0 on the same edge. Other channels are untouched.
- Latency: the record is written at the tlast edge, and status_valid is asserted in the following cycle (1 cycle after the tlast beat) when the FIFO was empty.
- FIFO: first-word-fall-through ordering, one push and one pop per cycle. A pop occurs when status_valid && status_ready.
- Push when the FIFO is full: the record is discarded even if a pop happens in the same cycle, and drop_count increments, saturating at all-ones. The channel counter still clears.
- Push and pop in the same cycle with the FIFO not full: occupancy is unchanged and ordering is preserved.
- Outputs are stable while status_valid=1 and status_ready=0.
- No internal state machine beyond the FIFO read/write pointers (LOG2(FIFO_DEPTH)+1 bits each, full/empty decided by pointer MSB compare).

Test Plan:
- Single channel, KEEP_WIDTH=8: tid=1, three beats with tkeep FF, FF, 0F (tlast) -> one cycle later status_valid=1, id=1, len=20, overflow=0.
- Interleaved channels: tid0 beat FF, tid2 beat FF, tid0 beat 03 (tlast), tid2 beat 01 (tlast) -> records in order {0,10,0}, then {2,9,0}.
- Non-contiguous keep: tkeep=0xA5 with tlast -> len=4. Beat with tkeep=0x00 adds 0, and a lone tlast with tkeep=0 -> len=0.
- Saturation, LEN_WIDTH=8: thirty-three 8-byte beats (264 bytes) on tid3, last with tlast -> len=255, overflow=1. The next tid3 frame of 8 bytes -> len=8, overflow=0.
- Backpressure, FIFO_DEPTH=4: status_ready=0, six 1-beat frames -> four records held, drop_count=2. Release ready -> the first four records emerge in order. Also a push and pop in the same cycle while full -> drop_count=3.
- Reset mid-frame: tid0 two beats (16 bytes), rst_n=0 for 1 cycle, then tid0 beat 0F with tlast -> len=4, status_valid was 0 during reset, drop_count=0.

Source files
------------

// File: rtl/axis_frame_len_mc.sv
// Passive multi-channel AXI4-Stream frame length monitor.
// Each tid has its own saturating byte counter. Completed frames are queued in a FWFT status FIFO.
module axis_frame_len_mc #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_WIDTH    = 2,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic [ID_WIDTH-1:0]   monitor_axis_tid,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  output logic [ID_WIDTH-1:0]   status_id,
  output logic [LEN_WIDTH-1:0]  status_len,
  output logic                  status_overflow,
  output logic                  status_valid,
  input  logic                  status_ready,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam int NUM_CH = 2 ** ID_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int REC_W  = ID_WIDTH + LEN_WIDTH + 1;

  logic [LEN_WIDTH-1:0] len_q [NUM_CH];
  logic                 ovf_q [NUM_CH];
  logic [REC_W-1:0]     mem   [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;

  logic [LEN_WIDTH:0]   inc, sum;
  logic [LEN_WIDTH-1:0] sat_len;
  logic                 beat_ovf, frame_ovf, beat, push, pop, full, empty, accept;
  logic [REC_W-1:0]     rd_rec;

  // The sum is one bit wider than the counter so that the carry out signals saturation.
  always_comb begin
    inc = '0;
    if (KEEP_ENABLE != 0) begin
      for (int i = 0; i < KEEP_WIDTH; i++)
        inc = inc + {{LEN_WIDTH{1'b0}}, monitor_axis_tkeep[i]};
    end else begin
      inc = (LEN_WIDTH + 1)'(1);
    end
    sum       = {1'b0, len_q[monitor_axis_tid]} + inc;
    beat_ovf  = sum[LEN_WIDTH];
    sat_len   = beat_ovf ? '1 : sum[LEN_WIDTH-1:0];
    frame_ovf = ovf_q[monitor_axis_tid] | beat_ovf;
  end

  assign beat   = monitor_axis_tvalid && monitor_axis_tready;
  assign push   = beat && monitor_axis_tlast;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && status_ready;
  assign accept = push && !full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        len_q[c] <= '0;
        ovf_q[c] <= 1'b0;
      end
    end else if (beat) begin
      if (monitor_axis_tlast) begin
        len_q[monitor_axis_tid] <= '0;
        ovf_q[monitor_axis_tid] <= 1'b0;
      end else begin
        len_q[monitor_axis_tid] <= sat_len;
        ovf_q[monitor_axis_tid] <= frame_ovf;
      end
    end
  end

  // A record that arrives when the FIFO is full is dropped, even if a pop frees a slot on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && full && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= {monitor_axis_tid, sat_len, frame_ovf};
  end

  assign rd_rec          = mem[rd_ptr[AW-1:0]];
  assign status_valid    = !empty;
  assign status_id       = empty ? '0 : rd_rec[REC_W-1 -: ID_WIDTH];
  assign status_len      = empty ? '0 : rd_rec[LEN_WIDTH:1];
  assign status_overflow = empty ? 1'b0 : rd_rec[0];

endmodule

// File: tb/tb_axis_frame_len_mc.sv
// Directed bench for axis_frame_len_mc with an 8-bit length counter and a 4-deep status FIFO.
module tb_axis_frame_len_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tkeep;
  logic [1:0] tid;
  logic       tvalid, tready, tlast;
  logic [1:0] status_id;
  logic [7:0] status_len;
  logic       status_overflow, status_valid, status_ready;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  axis_frame_len_mc #(
    .DATA_WIDTH(64), .KEEP_ENABLE(1), .KEEP_WIDTH(8), .ID_WIDTH(2),
    .LEN_WIDTH(8), .FIFO_DEPTH(4), .DROP_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .monitor_axis_tkeep(tkeep), .monitor_axis_tid(tid),
    .monitor_axis_tvalid(tvalid), .monitor_axis_tready(tready),
    .monitor_axis_tlast(tlast),
    .status_id(status_id), .status_len(status_len),
    .status_overflow(status_overflow), .status_valid(status_valid),
    .status_ready(status_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input int id, input int len, input int ovf);
    check_val({tag, ".valid"}, 32'(status_valid), 32'd1);
    check_val({tag, ".id"}, 32'(status_id), 32'(id));
    check_val({tag, ".len"}, 32'(status_len), 32'(len));
    check_val({tag, ".ovf"}, 32'(status_overflow), 32'(ovf));
  endtask

  // One handshaken beat between negedges, optionally popping in the same cycle.
  task automatic apply_beat(input logic [1:0] id, input logic [7:0] keep, input logic last,
                            input logic rdy);
    tid = id; tkeep = keep; tlast = last; tvalid = 1'b1; tready = 1'b1; status_ready = rdy;
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; status_ready = 1'b0;
  endtask

  task automatic pop_one();
    status_ready = 1'b1;
    @(negedge clk);
    status_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tkeep = '0; tid = '0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    status_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst.valid", 32'(status_valid), 32'd0);
    check_val("rst.id", 32'(status_id), 32'd0);
    check_val("rst.len", 32'(status_len), 32'd0);
    check_val("rst.ovf", 32'(status_overflow), 32'd0);
    check_val("rst.drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single channel, including a beat with tready low that must be ignored.
    apply_beat(2'd1, 8'hFF, 1'b0, 1'b0);
    tid = 2'd1; tkeep = 8'hFF; tvalid = 1'b1; tready = 1'b0;
    @(negedge clk);
    tvalid = 1'b0;
    apply_beat(2'd1, 8'hFF, 1'b0, 1'b0);
    check_val("single.pre", 32'(status_valid), 32'd0);
    apply_beat(2'd1, 8'h0F, 1'b1, 1'b0);
    check_rec("single", 1, 20, 0);
    pop_one();
    check_val("single.empty", 32'(status_valid), 32'd0);

    // Interleaved channels.
    apply_beat(2'd0, 8'hFF, 1'b0, 1'b0);
    apply_beat(2'd2, 8'hFF, 1'b0, 1'b0);
    apply_beat(2'd0, 8'h03, 1'b1, 1'b0);
    apply_beat(2'd2, 8'h01, 1'b1, 1'b0);
    check_rec("ilv0", 0, 10, 0);
    pop_one();
    check_rec("ilv2", 2, 9, 0);
    pop_one();
    check_val("ilv.empty", 32'(status_valid), 32'd0);

    // Non-contiguous keep and zero-keep beats.
    apply_beat(2'd1, 8'hA5, 1'b1, 1'b0);
    check_rec("keepA5", 1, 4, 0);
    pop_one();
    apply_beat(2'd1, 8'h00, 1'b0, 1'b0);
    apply_beat(2'd1, 8'h00, 1'b1, 1'b0);
    check_rec("keep00", 1, 0, 0);
    pop_one();

    // Exactly 255 bytes fits without overflow.
    for (int i = 0; i < 31; i++) apply_beat(2'd3, 8'hFF, 1'b0, 1'b0);
    apply_beat(2'd3, 8'h7F, 1'b1, 1'b0);
    check_rec("max", 3, 255, 0);
    pop_one();

    // 264 bytes saturates.
    for (int i = 0; i < 32; i++) apply_beat(2'd3, 8'hFF, 1'b0, 1'b0);
    apply_beat(2'd3, 8'hFF, 1'b1, 1'b0);
    check_rec("sat", 3, 255, 1);
    pop_one();
    apply_beat(2'd3, 8'hFF, 1'b1, 1'b0);
    check_rec("after_sat", 3, 8, 0);
    pop_one();

    // Overflow from an earlier beat must stick when the last beat adds nothing.
    for (int i = 0; i < 32; i++) apply_beat(2'd2, 8'hFF, 1'b0, 1'b0);
    apply_beat(2'd2, 8'h00, 1'b1, 1'b0);
    check_rec("sticky", 2, 255, 1);
    pop_one();

    // Backpressure: six frames into a 4-deep FIFO.
    apply_beat(2'd0, 8'h01, 1'b1, 1'b0);
    apply_beat(2'd1, 8'h03, 1'b1, 1'b0);
    apply_beat(2'd2, 8'h07, 1'b1, 1'b0);
    apply_beat(2'd3, 8'h0F, 1'b1, 1'b0);
    apply_beat(2'd0, 8'h1F, 1'b1, 1'b0);
    apply_beat(2'd1, 8'h3F, 1'b1, 1'b0);
    check_val("bp.drop2", 32'(drop_count), 32'd2);
    check_rec("bp.r0", 0, 1, 0);
    apply_beat(2'd2, 8'hFF, 1'b1, 1'b1);
    check_val("bp.drop3", 32'(drop_count), 32'd3);
    check_rec("bp.r1", 1, 2, 0);
    pop_one();
    check_rec("bp.r2", 2, 3, 0);
    pop_one();
    check_rec("bp.r3", 3, 4, 0);
    pop_one();
    check_val("bp.empty", 32'(status_valid), 32'd0);

    // Push and pop together with one entry queued.
    apply_beat(2'd0, 8'h01, 1'b1, 1'b0);
    apply_beat(2'd1, 8'h03, 1'b1, 1'b1);
    check_rec("pushpop", 1, 2, 0);
    pop_one();
    check_val("pushpop.empty", 32'(status_valid), 32'd0);

    // Reset in the middle of a frame discards it and clears the drop counter.
    apply_beat(2'd0, 8'hFF, 1'b0, 1'b0);
    apply_beat(2'd0, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst.valid", 32'(status_valid), 32'd0);
    check_val("midrst.drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    apply_beat(2'd0, 8'h0F, 1'b1, 1'b0);
    check_rec("midrst", 0, 4, 0);
    check_val("midrst.drop_after", 32'(drop_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
